mem_responder: RTL and testbench

//   Memory-side responder for the multicycle control unit's MemRead/MemWrite strobes.

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM behind a MemRead/MemWrite strobe interface.
// It serves one request at a time, adds WAIT_CYCLES wait states, and then
// returns a one-cycle MemReady pulse. A rejected request also raises MemError
// in that same cycle.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for MemRead|MemWrite; request fields latched on entry
//   S_BUSY | counting wait states; access performed on the cnt==0 edge
//   S_DONE | MemReady/MemError high for this one cycle; strobes ignored
module mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              MemError,
  output logic              Busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [DATA_W-1:0] mem [0:(2**ADDR_BITS)-1];

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;
  logic                   ram_we;

  // Bits of Addr above the word index only alias; they never select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr[15:ADDR_BITS+1];

  // Next-state logic: latch the request in IDLE, count down the wait states in
  // BUSY, then complete the access when the count reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          op_wr_d = MemWrite;
          idx_d   = Addr[ADDR_BITS:1];
          wdata_d = WriteData;
          err_d   = (MemRead && MemWrite) || Addr[0];
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          error_d = err_q;
          state_d = S_DONE;
          if (!err_q) begin
            if (op_wr_q) ram_we  = 1'b1;
            else         rdata_d = mem[idx_q];
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers. Reset wins over a completion on the same edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Reset does not clear the RAM, but it does suppress a write that would
  // otherwise complete on the same edge.
  always_ff @(posedge CLK) begin
    if (ram_we && !Reset) mem[idx_q] <= wdata_q;
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemError = error_q;
  assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (WAIT_CYCLES=2, ADDR_BITS=10).
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] Addr;
  logic [15:0] WriteData;
  logic [15:0] ReadData;
  logic        MemReady;
  logic        MemError;
  logic        Busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ref_mem [0:1023];
  logic [15:0] last_rd;

  mem_responder #(.DATA_W(16), .ADDR_BITS(10), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .MemReady(MemReady), .MemError(MemError), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request and hold it until MemReady, then drop the strobes.
  // The completion pulse is expected on the 4th edge counted from the request
  // edge. Optionally scramble Addr and WriteData while BUSY.
  task automatic do_req(input string nm, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic exp_err, input logic [15:0] exp_rd,
                        input bit scramble);
    int n = 0;
    bit seen = 0;
    MemRead = rd; MemWrite = wr; Addr = addr; WriteData = wdata;
    while (!seen && n < 20) begin
      @(posedge CLK); #1;
      n++;
      if (scramble && n == 1) begin
        Addr = 16'($urandom);
        WriteData = 16'($urandom);
      end
      if (MemReady === 1'b1) seen = 1;
    end
    chk({nm, ".latency"}, 32'(n), 32'd4);
    chk({nm, ".MemError"}, 32'(MemError), 32'(exp_err));
    chk({nm, ".ReadData"}, 32'(ReadData), 32'(exp_rd));
    chk({nm, ".Busy_done"}, 32'(Busy), 32'd1);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge CLK); #1;
    chk({nm, ".MemReady_off"}, 32'(MemReady), 32'd0);
    chk({nm, ".MemError_off"}, 32'(MemError), 32'd0);
    chk({nm, ".Busy_idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    vec_t vt [10];
    int p1, p2, pulses;

    Reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr = 16'h0010; WriteData = 16'h0;

    // Reset held for three cycles while a read is requested.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("reset.MemReady", 32'(MemReady), 32'd0);
      chk("reset.Busy", 32'(Busy), 32'd0);
      chk("reset.ReadData", 32'(ReadData), 32'd0);
    end
    Reset = 1'b0; MemRead = 1'b0;

    // Directed vectors: write/read, rejected requests, address aliasing.
    vt[0] = '{"wr_beef",   1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vt[1] = '{"rd_beef",   1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vt[2] = '{"wr_20",     1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'hBEEF};
    vt[3] = '{"both_err",  1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'hBEEF};
    vt[4] = '{"rd_20",     1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1111};
    vt[5] = '{"wr_1234",   1'b0, 1'b1, 16'h0002, 16'h1234, 1'b0, 16'h1111};
    vt[6] = '{"rd_wrap",   1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0, 16'h1234};
    vt[7] = '{"rd_odd",    1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h1234};
    vt[8] = '{"wr_40",     1'b0, 1'b1, 16'h0040, 16'hA5A5, 1'b0, 16'h1234};
    vt[9] = '{"rd_40",     1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'hA5A5};
    for (int i = 0; i < 10; i++)
      do_req(vt[i].name, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata,
             vt[i].exp_err, vt[i].exp_rd, 1'b0);

    // A write is interrupted by a one-cycle Reset while cnt==1, so it must not
    // complete and must leave the RAM unchanged.
    MemWrite = 1'b1; Addr = 16'h0040; WriteData = 16'h5555;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0; MemWrite = 1'b0;
    chk("abort.Busy", 32'(Busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (MemReady === 1'b1) pulses++;
    end
    chk("abort.no_ready", 32'(pulses), 32'd0);
    do_req("abort_rd", 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'hA5A5, 1'b0);

    // MemRead is held high through DONE, so it is taken as a second request.
    // The two pulses are five edges apart, with four quiet cycles between them.
    MemRead = 1'b1; Addr = 16'h0010;
    p1 = 0; p2 = 0; pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK); #1;
      if (MemReady === 1'b1) begin
        pulses++;
        if (pulses == 1) p1 = c;
        if (pulses == 2) begin
          p2 = c;
          MemRead = 1'b0;
          chk("held.ReadData", 32'(ReadData), 32'hBEEF);
        end
      end
    end
    MemRead = 1'b0;
    chk("held.pulses", 32'(pulses), 32'd2);
    chk("held.first", 32'(p1), 32'd4);
    chk("held.gap", 32'(p2 - p1), 32'd5);
    last_rd = 16'hBEEF;

    // Randomized phase: preload words 0..63, then issue random traffic and
    // compare it against the reference array.
    for (int w = 0; w < 64; w++) begin
      logic [15:0] d;
      d = 16'($urandom);
      ref_mem[w] = d;
      do_req("preload", 1'b0, 1'b1, 16'(w << 1), d, 1'b0, last_rd, 1'b0);
    end
    for (int t = 0; t < 300; t++) begin
      int r, w;
      logic rd, wr, both, odd, err;
      logic [15:0] a, d;
      r = int'($urandom_range(0, 7));
      both = (r == 7);
      rd = (r < 4) || both;
      wr = (r >= 4 && r < 7) || both;
      odd = ($urandom_range(0, 7) == 0);
      w = int'($urandom_range(0, 63));
      a = (16'($urandom) & 16'hF800) | 16'(w << 1) | {15'd0, odd};
      d = 16'($urandom);
      err = both || odd;
      if (!err && wr) ref_mem[w] = d;
      if (!err && rd) last_rd = ref_mem[w];
      do_req("random", rd, wr, a, d, err, last_rd, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
